// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states,
// access size encoding and byte-lane selectors.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } lsu_state_t;

  typedef enum logic {
    SIZE_BYTE = 1'b0,
    SIZE_HALF = 1'b1
  } lsu_size_t;

  localparam logic LANE_LO = 1'b0;
  localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/lsu_byte_lane.sv
// Byte-lane helper: extracts one byte of a 16-bit word with sign/zero
// extension, and merges a new byte into the selected lane.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [15:0] word,
  input  logic        lane,
  input  logic        sign_ext,
  input  logic [7:0]  new_byte,
  output logic [15:0] extracted,
  output logic [15:0] merged
);

  logic [7:0] sel_byte;

  always_comb begin
    sel_byte  = (lane == LANE_HI) ? word[15:8] : word[7:0];
    extracted = {{8{sign_ext & sel_byte[7]}}, sel_byte};
    merged    = (lane == LANE_HI) ? {new_byte, word[7:0]} : {word[15:8], new_byte};
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store sequencer: byte/halfword accesses with RMW for byte
// stores. Optional misaligned-halfword trap: define LSU_MISALIGN_TRAP_EN.
//
// Request handshake: a request transfers on a rising edge where
// req_valid && req_ready; req_ready is high only in IDLE, and req_* are
// don't-care whenever req_ready is low. resp_valid is a one-cycle pulse.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_error,
  output lsu_state_t        dbg_state
);

  lsu_state_t        state_q, state_d;
  logic              cap_write;
  lsu_size_t         cap_size;
  logic              cap_signed;
  logic [ADDR_W-1:0] cap_addr;
  logic [7:0]        cap_byte;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              req_is_half;
  logic              trap_hit;
  logic [DATA_W-1:0] lane_extracted;
  logic [DATA_W-1:0] lane_merged;

  assign req_ready   = (state_q == IDLE);
  assign accept      = req_valid & req_ready;
  assign req_is_half = (lsu_size_t'(req_size) == SIZE_HALF);

`ifdef LSU_MISALIGN_TRAP_EN
  logic err_q;

  assign trap_hit   = req_is_half & req_addr[0];
  assign resp_error = err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= trap_hit;
    end
  end
`else
  assign trap_hit   = 1'b0;
  assign resp_error = 1'b0;
`endif

  lsu_byte_lane u_byte_lane (
    .word      (mem_read_data),
    .lane      (cap_addr[0]),
    .sign_ext  (cap_signed),
    .new_byte  (cap_byte),
    .extracted (lane_extracted),
    .merged    (lane_merged)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (trap_hit)                      state_d = RESP;
          else if (req_write && req_is_half) state_d = WRITE;
          else                               state_d = READ;
        end
      end
      READ:    state_d = cap_write ? WRITE : RESP;
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Captured request plus the registered write word and load result; the
  // byte-store merge happens on the READ edge so WRITE only replays wdata_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_write  <= 1'b0;
      cap_size   <= SIZE_BYTE;
      cap_signed <= 1'b0;
      cap_addr   <= '0;
      cap_byte   <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cap_write  <= req_write;
            cap_size   <= lsu_size_t'(req_size);
            cap_signed <= req_signed;
            cap_addr   <= req_addr;
            cap_byte   <= req_wdata[7:0];
            if (req_write && req_is_half && !trap_hit) wdata_q <= req_wdata;
            if (trap_hit) rdata_q <= '0;
          end
        end
        READ: begin
          if (cap_write) wdata_q <= lane_merged;
          else rdata_q <= (cap_size == SIZE_HALF) ? mem_read_data : lane_extracted;
        end
        WRITE:   rdata_q <= '0;
        default: ;
      endcase
    end
  end

  assign mem_address      = {1'b0, cap_addr[ADDR_W-1:1]};
  assign mem_write_data   = wdata_q;
  assign mem_read_enable  = (state_q == READ);
  assign mem_write_enable = (state_q == WRITE);
  assign resp_valid       = (state_q == RESP);
  assign resp_rdata       = rdata_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed test-plan cases, an
// abort-by-reset case, back-to-back requests and randomized traffic.
module tb_load_store_unit;
  import lsu_pkg::*;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_size = 1'b0;
  logic        req_signed = 1'b0;
  logic [15:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [15:0] mem_address;
  logic [15:0] mem_write_data;
  logic        mem_write_enable;
  logic        mem_read_enable;
  logic [15:0] mem_read_data;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_error;
  lsu_state_t  dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  load_store_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_size         (req_size),
    .req_signed       (req_signed),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_error       (resp_error),
    .dbg_state        (dbg_state)
  );

  // ---------------- memory the DUT talks to ----------------
  logic [15:0] env_mem [0:32767];
  logic [15:0] ref_mem [0:32767];

  assign mem_read_data = env_mem[mem_address[14:0]];

  initial begin
    for (int i = 0; i < 32768; i++) env_mem[i] = 16'h0000;
    forever begin
      @(posedge clk);
      if (mem_write_enable) env_mem[mem_address[14:0]] = mem_write_data;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [16:0] exp_q[$];   // {error, rdata}
  logic [16:0] sb_entry;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          resp_cnt = 0;
  logic [15:0] strobe_addr = '0;
  logic [15:0] wr_data_seen = '0;

  always @(negedge clk) begin
    if (mem_read_enable) begin
      rd_cnt++;
      strobe_addr = mem_address;
    end
    if (mem_write_enable) begin
      wr_cnt++;
      strobe_addr  = mem_address;
      wr_data_seen = mem_write_data;
    end
    if (resp_valid) begin
      resp_cnt++;
      if (exp_q.size() == 0) begin
        check("resp_unexpected", {15'd0, resp_valid}, 16'd0);
      end else begin
        sb_entry = exp_q.pop_front();
        check("resp_rdata", resp_rdata, sb_entry[15:0]);
        check("resp_error", {15'd0, resp_error}, {15'd0, sb_entry[16]});
      end
    end
  end

  // ---------------- driver with reference model ----------------
  task automatic lsu_op(input logic wr, input logic sz, input logic sg,
                        input logic [15:0] addr, input logic [15:0] wd,
                        output int ready_wait);
    logic [14:0] wa;
    logic        trap;
    logic [15:0] word;
    logic [15:0] exp_rdata;
    logic [7:0]  b;
    int          exp_lat, exp_rd, exp_wr, cyc;

    wa   = addr[15:1];
    trap = TRAP_EN && sz && addr[0];
    word = ref_mem[wa];
    b    = addr[0] ? word[15:8] : word[7:0];
    if (trap || wr)  exp_rdata = 16'h0000;
    else if (sz)     exp_rdata = word;
    else if (sg)     exp_rdata = {{8{b[7]}}, b};
    else             exp_rdata = {8'h00, b};
    exp_lat = trap ? 1 : ((wr && !sz) ? 3 : 2);
    exp_rd  = (trap || (wr && sz)) ? 0 : 1;
    exp_wr  = (!trap && wr) ? 1 : 0;
    if (!trap && wr) begin
      if (sz)           ref_mem[wa] = wd;
      else if (addr[0]) ref_mem[wa] = {wd[7:0], word[7:0]};
      else              ref_mem[wa] = {word[15:8], wd[7:0]};
    end
    exp_q.push_back({trap, exp_rdata});

    req_valid  = 1'b1;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    ready_wait = 0;
    while (!req_ready && ready_wait < 20) begin
      @(negedge clk);
      ready_wait++;
    end
    if (ready_wait >= 20) check("ready_timeout", {15'd0, req_ready}, 16'd1);

    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom_range(0, 1));
    req_size   = 1'($urandom_range(0, 1));
    req_signed = 1'($urandom_range(0, 1));
    req_addr   = 16'($urandom);
    req_wdata  = 16'($urandom);
    rd_cnt = 0;
    wr_cnt = 0;

    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      check("ready_busy", {15'd0, req_ready}, 16'd0);
    end while (!resp_valid && cyc < 8);
    #1;
    check("latency", 16'(cyc), 16'(exp_lat));
    check("read_strobes", 16'(rd_cnt), 16'(exp_rd));
    check("write_strobes", 16'(wr_cnt), 16'(exp_wr));
    if (exp_rd + exp_wr > 0) check("strobe_addr", strobe_addr, {1'b0, wa});
    if (exp_wr > 0) check("write_data", wr_data_seen, ref_mem[wa]);
    check("mem_word", env_mem[wa], ref_mem[wa]);
  endtask

  // ---------------- stimulus ----------------
  int          rw, rw2;
  logic [15:0] r_addr;

  initial begin
    for (int i = 0; i < 32768; i++) ref_mem[i] = 16'h0000;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {15'd0, req_ready}, 16'd1);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {15'd0, req_ready}, 16'd1);
    check("reset_resp_valid", {15'd0, resp_valid}, 16'd0);
    check("reset_resp_error", {15'd0, resp_error}, 16'd0);
    check("reset_resp_rdata", resp_rdata, 16'h0000);
    check("reset_rd_en", {15'd0, mem_read_enable}, 16'd0);
    check("reset_wr_en", {15'd0, mem_write_enable}, 16'd0);
    check("reset_mem_address", mem_address, 16'h0000);
    check("reset_mem_wdata", mem_write_data, 16'h0000);
    check("reset_state", 16'(dbg_state), 16'(IDLE));

    // Directed cases from the test plan
    lsu_op(1'b1, 1'b1, 1'b0, 16'h0010, 16'hBEEF, rw);
    lsu_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rw);
    lsu_op(1'b1, 1'b0, 1'b0, 16'h0011, 16'hAB12, rw);
    check("plan_byte_merge", env_mem[8], 16'h12EF);
    lsu_op(1'b0, 1'b0, 1'b1, 16'h0010, 16'h0000, rw);
    lsu_op(1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, rw);
    lsu_op(1'b0, 1'b0, 1'b1, 16'h0011, 16'h0000, rw);
    lsu_op(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, rw);
    lsu_op(1'b1, 1'b1, 1'b0, 16'h0013, 16'hC3A5, rw);
    lsu_op(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'h805A, rw);
    lsu_op(1'b0, 1'b0, 1'b1, 16'hFFFF, 16'h0000, rw);
    lsu_op(1'b0, 1'b0, 1'b1, 16'hFFFE, 16'h0000, rw);
    lsu_op(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'h0077, rw);
    check("plan_wrap_word", env_mem[15'h7FFF], 16'h775A);

    // Reset while a byte store is in READ: the access must vanish
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 1'b0; req_signed = 1'b0;
    req_addr = 16'h0011; req_wdata = 16'h0034;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rd_cnt = 0; wr_cnt = 0; resp_cnt = 0;
    @(negedge clk);
    check("abort_in_read", 16'(dbg_state), 16'(READ));
    #1 rst_n = 1'b0;
    #1 check("abort_async_idle", 16'(dbg_state), 16'(IDLE));
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    check("abort_no_write", 16'(wr_cnt), 16'd0);
    check("abort_no_resp", 16'(resp_cnt), 16'd0);
    check("abort_ready", {15'd0, req_ready}, 16'd1);
    check("abort_mem_kept", env_mem[8], ref_mem[8]);

    // Back-to-back: second request is already valid during the first RESP
    @(negedge clk);
    lsu_op(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, rw);
    lsu_op(1'b0, 1'b0, 1'b0, 16'h0011, 16'h0000, rw2);
    check("b2b_first_wait", 16'(rw), 16'd0);
    check("b2b_second_wait", 16'(rw2), 16'd1);

    // Randomized traffic, mostly in a small window so loads hit stored data
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) r_addr = 16'($urandom);
      else r_addr = 16'($urandom_range(0, 63));
      lsu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), r_addr, 16'($urandom), rw);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 16'(exp_q.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
